// File: rtl/score_update_scheduler_pkg.sv
// Shared constants for the HUD score update scheduler: default blanking line,
// score ceiling and the 2-bit scheduler state encodings.
package score_update_scheduler_pkg;
    localparam int V_VISIBLE_DEF = 480;
    localparam logic [6:0] MAX_SCORE = 7'd99;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
endpackage

// File: rtl/score_update_scheduler_bcd2_counter.sv
// Two-digit BCD counter that saturates at 99, with a binary mirror of the value.
// Clear takes priority over increment.
module bcd2_counter
    import score_update_scheduler_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] dec_o,
    output logic [3:0] unit_o,
    output logic [6:0] bin_o
);
    logic [3:0] dec_q, dec_d, unit_q, unit_d;
    logic [6:0] bin_q, bin_d;

    always_comb begin
        dec_d  = dec_q;
        unit_d = unit_q;
        bin_d  = bin_q;
        if (clr_i) begin
            dec_d  = '0;
            unit_d = '0;
            bin_d  = '0;
        end else if (inc_i && bin_q != MAX_SCORE) begin
            bin_d = bin_q + 7'd1;
            if (unit_q == 4'd9) begin
                unit_d = '0;
                dec_d  = dec_q + 4'd1;
            end else begin
                unit_d = unit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_q  <= '0;
            unit_q <= '0;
            bin_q  <= '0;
        end else begin
            dec_q  <= dec_d;
            unit_q <= unit_d;
            bin_q  <= bin_d;
        end
    end

    assign dec_o  = dec_q;
    assign unit_o = unit_q;
    assign bin_o  = bin_q;
endmodule

// File: rtl/score_update_scheduler.sv
// Queues food-eaten events and applies them to the BCD score only during vertical blanking.
// Optional high-score tracking is enabled with the SCORE_HIGH_SCORE_EN macro.
module score_update_scheduler
    import score_update_scheduler_pkg::*;
#(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int V_VISIBLE         = V_VISIBLE_DEF,
    parameter int PEND_BITS         = 3
) (
    input  logic                       clock_25,
    input  logic                       sync_reset,
    input  logic                       eat_pulse,
    input  logic                       game_over,
    input  logic                       new_game,
    input  logic [PIXEL_DISPLAY_BIT:0] Y,
    output logic [3:0]                 score_dec,
    output logic [3:0]                 score_unit,
    output logic [6:0]                 score,
    output logic [PEND_BITS-1:0]       pending,
    output logic                       overflow,
    output logic                       frame_update,
    output logic                       busy
`ifdef SCORE_HIGH_SCORE_EN
    ,
    output logic [3:0]                 hi_dec,
    output logic [3:0]                 hi_unit
`endif
);
    localparam logic [PIXEL_DISPLAY_BIT:0] V_VIS    = (PIXEL_DISPLAY_BIT+1)'(V_VISIBLE);
    localparam logic [PEND_BITS-1:0]       PEND_MAX = '1;
    localparam logic [PEND_BITS-1:0]       PEND_ONE = PEND_BITS'(1);

    logic [1:0]           state_q, state_d;
    logic [PEND_BITS-1:0] pend_q, pend_d;
    logic                 ovf_q, ovf_d, clr_req_q, clr_req_d, fu_q, fu_d;
    logic                 blank, eat_acc, in_apply, in_clear;

    assign blank    = (Y >= V_VIS);
    assign eat_acc  = eat_pulse & ~game_over;
    assign in_apply = (state_q == ST_APPLY);
    assign in_clear = (state_q == ST_CLEAR);

    always_comb begin
        state_d = state_q;
        fu_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req_q && blank)
                    state_d = ST_CLEAR;
                else if (pend_q != '0 && blank && !game_over)
                    state_d = ST_APPLY;
            end
            ST_APPLY: begin
                // A pending clear also ends the run so CLEAR can take the next blank cycle.
                if ((pend_q == PEND_ONE && !eat_acc) || !blank || game_over || new_game || clr_req_q) begin
                    state_d = ST_IDLE;
                    fu_d    = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
                fu_d    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (in_clear) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (eat_acc && !in_apply) begin
            if (pend_q == PEND_MAX)
                ovf_d = 1'b1;
            else
                pend_d = pend_q + PEND_ONE;
        end else if (!eat_acc && in_apply) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    assign clr_req_d = new_game | (clr_req_q & ~in_clear);

    always_ff @(posedge clock_25) begin
        if (sync_reset) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            clr_req_q <= 1'b0;
            fu_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            clr_req_q <= clr_req_d;
            fu_q      <= fu_d;
        end
    end

    bcd2_counter u_score (
        .clk_i  (clock_25),
        .rst_i  (sync_reset),
        .inc_i  (in_apply),
        .clr_i  (in_clear),
        .dec_o  (score_dec),
        .unit_o (score_unit),
        .bin_o  (score)
    );

`ifdef SCORE_HIGH_SCORE_EN
    logic       go_q;
    logic [6:0] hi_bin_q;
    logic [3:0] hi_dec_q, hi_unit_q;

    always_ff @(posedge clock_25) begin
        if (sync_reset) begin
            go_q      <= 1'b0;
            hi_bin_q  <= '0;
            hi_dec_q  <= '0;
            hi_unit_q <= '0;
        end else begin
            go_q <= game_over;
            if (game_over && !go_q && score > hi_bin_q) begin
                hi_bin_q  <= score;
                hi_dec_q  <= score_dec;
                hi_unit_q <= score_unit;
            end
        end
    end

    assign hi_dec  = hi_dec_q;
    assign hi_unit = hi_unit_q;
`endif

    assign pending      = pend_q;
    assign overflow     = ovf_q;
    assign frame_update = fu_q;
    assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_score_update_scheduler.sv
// Bench for score_update_scheduler: directed scenarios plus a randomized run checked
// against a behavioural score/queue model.
module tb_score_update_scheduler;
    logic       clk = 1'b0;
    logic       rst, eat, go, ng;
    logic [9:0] y;
    logic [3:0] score_dec, score_unit;
    logic [6:0] score;
    logic [2:0] pending;
    logic       overflow, frame_update, busy;
`ifdef SCORE_HIGH_SCORE_EN
    logic [3:0] hi_dec, hi_unit;
`endif

    score_update_scheduler #(.PIXEL_DISPLAY_BIT(9), .V_VISIBLE(480), .PEND_BITS(3)) dut (
        .clock_25(clk), .sync_reset(rst), .eat_pulse(eat), .game_over(go), .new_game(ng), .Y(y),
        .score_dec(score_dec), .score_unit(score_unit), .score(score), .pending(pending),
        .overflow(overflow), .frame_update(frame_update), .busy(busy)
`ifdef SCORE_HIGH_SCORE_EN
        , .hi_dec(hi_dec), .hi_unit(hi_unit)
`endif
    );

    always #20 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Behavioural model: mode 0 waiting, 1 applying, 2 clearing
    int m_score, m_pend, m_mode, m_hi;
    bit m_ovf, m_req, m_fu, m_go_prev;

    task automatic model_tick();
        bit blank = (y >= 10'd480);
        bit acc = eat && !go;
        int nmode;
        int npend;
        if (rst) begin
            m_score = 0; m_pend = 0; m_mode = 0; m_hi = 0;
            m_ovf = 0; m_req = 0; m_fu = 0; m_go_prev = 0;
            return;
        end
        if (go && !m_go_prev && m_score > m_hi) m_hi = m_score;
        m_go_prev = go;
        nmode = m_mode;
        m_fu = 0;
        if (m_mode == 2) begin
            npend = 0;
            m_ovf = 0;
        end else begin
            npend = m_pend + (acc ? 1 : 0) - (m_mode == 1 ? 1 : 0);
            if (npend > 7) begin npend = 7; m_ovf = 1; end
        end
        case (m_mode)
            0: if (m_req && blank) nmode = 2;
               else if (m_pend > 0 && blank && !go) nmode = 1;
            1: begin
                if (m_score < 99) m_score = m_score + 1;
                if ((m_pend == 1 && !acc) || !blank || go || ng || m_req) begin nmode = 0; m_fu = 1; end
            end
            default: begin m_score = 0; nmode = 0; m_fu = 1; end
        endcase
        m_req = ng ? 1'b1 : (m_mode == 2 ? 1'b0 : m_req);
        m_pend = npend;
        m_mode = nmode;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    // Stimulus only: queue n events in the visible area, then let one blank apply them.
    task automatic add_events(input int n);
        y = 10'd100;
        eat = 1'b1;
        repeat (n) step();
        eat = 1'b0;
        y = 10'd480;
        repeat (n + 4) step();
        y = 10'd100;
        step();
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; eat = 1'b0; go = 1'b0; ng = 1'b0; y = 10'd0;
        repeat (3) begin
            step();
            if ({score_dec, score_unit, score, pending, overflow, frame_update, busy} !== 21'd0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL reset_outputs: %0d nonzero cycles, required 0", bad);
        else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_apply_burst();
        int seq[6];
        int fu_cnt = 0;
        y = 10'd100;
        eat = 1'b1; repeat (3) step(); eat = 1'b0;
        step();
        checks++;
        if (pending !== 3'd3 || score !== 7'd0) $display("FAIL burst_queue: pending=%0d score=%0d, required 3 and 0", pending, score);
        else passed++;
        y = 10'd480;
        for (int i = 0; i < 6; i++) begin
            step();
            seq[i] = score;
            if (frame_update) fu_cnt++;
        end
        checks++;
        if (seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3 || seq[5] != 3)
            $display("FAIL burst_seq: %0d %0d %0d %0d %0d, required 0 1 2 3 3", seq[0], seq[1], seq[2], seq[3], seq[5]);
        else passed++;
        checks++;
        if (fu_cnt != 1 || pending !== 3'd0 || busy !== 1'b0)
            $display("FAIL burst_end: frame_updates=%0d pending=%0d busy=%0d, required 1 0 0", fu_cnt, pending, busy);
        else passed++;
        y = 10'd100;
        step();
    endtask

    task automatic test_carry();
        add_events(6);
        checks++;
        if (score !== 7'd9) $display("FAIL carry_pre: score=%0d, required 9", score);
        else passed++;
        add_events(1);
        checks++;
        if (score_dec !== 4'd1 || score_unit !== 4'd0 || score !== 7'd10)
            $display("FAIL carry: %0d%0d bin %0d, required 10 bin 10", score_dec, score_unit, score);
        else passed++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20 && m_score < 99; i++) add_events((99 - m_score) > 7 ? 7 : (99 - m_score));
        add_events(2);
        checks++;
        if (score !== 7'd99 || score_dec !== 4'd9 || score_unit !== 4'd9 || pending !== 3'd0 || overflow !== 1'b0)
            $display("FAIL saturate: score=%0d pending=%0d overflow=%0d, required 99 0 0", score, pending, overflow);
        else passed++;
    endtask

    task automatic test_clear();
        y = 10'd100;
        ng = 1'b1; step(); ng = 1'b0;
        repeat (3) step();
        checks++;
        if (score !== 7'd99 || busy !== 1'b0) $display("FAIL clear_wait: score=%0d busy=%0d, required 99 0", score, busy);
        else passed++;
        y = 10'd480;
        step();
        checks++;
        if (busy !== 1'b1 || score !== 7'd99) $display("FAIL clear_state: busy=%0d score=%0d, required 1 99", busy, score);
        else passed++;
        step();
        checks++;
        if (score !== 7'd0 || overflow !== 1'b0 || frame_update !== 1'b1 || busy !== 1'b0)
            $display("FAIL clear_done: score=%0d ovf=%0d fu=%0d busy=%0d, required 0 0 1 0", score, overflow, frame_update, busy);
        else passed++;
        y = 10'd100;
        step();
    endtask

    task automatic test_overflow();
        y = 10'd100;
        eat = 1'b1; repeat (8) step(); eat = 1'b0;
        checks++;
        if (pending !== 3'd7 || overflow !== 1'b1) $display("FAIL overflow: pending=%0d ovf=%0d, required 7 1", pending, overflow);
        else passed++;
        y = 10'd480;
        step(); step();
        eat = 1'b1; step(); eat = 1'b0;
        checks++;
        if (pending !== 3'd6 || score !== 7'd2) $display("FAIL eat_in_apply: pending=%0d score=%0d, required 6 2", pending, score);
        else passed++;
        y = 10'd0;
        repeat (4) step();
        checks++;
        if (score !== 7'd3 || pending !== 3'd5 || busy !== 1'b0)
            $display("FAIL visible_stop: score=%0d pending=%0d busy=%0d, required 3 5 0", score, pending, busy);
        else passed++;
        y = 10'd480;
        repeat (8) step();
        checks++;
        if (score !== 7'd8 || pending !== 3'd0 || overflow !== 1'b1)
            $display("FAIL resume: score=%0d pending=%0d ovf=%0d, required 8 0 1", score, pending, overflow);
        else passed++;
        y = 10'd100;
        step();
    endtask

    task automatic test_game_over();
        ng = 1'b1; step(); ng = 1'b0;
        y = 10'd480; repeat (3) step(); y = 10'd100; step();
        repeat (6) add_events(7);
        checks++;
        if (score !== 7'd42) $display("FAIL reach42: score=%0d, required 42", score);
        else passed++;
        go = 1'b1; step();
        eat = 1'b1; step(); eat = 1'b0;
        y = 10'd480; repeat (3) step(); y = 10'd100;
        checks++;
        if (pending !== 3'd0 || score !== 7'd42) $display("FAIL go_ignore: pending=%0d score=%0d, required 0 42", pending, score);
        else passed++;
        ng = 1'b1; step(); ng = 1'b0; repeat (2) step();
        checks++;
        if (score !== 7'd42) $display("FAIL go_clear_wait: score=%0d, required 42", score);
        else passed++;
        y = 10'd480; repeat (3) step();
        checks++;
        if (score !== 7'd0 || overflow !== 1'b0) $display("FAIL go_clear: score=%0d ovf=%0d, required 0 0", score, overflow);
        else passed++;
`ifdef SCORE_HIGH_SCORE_EN
        checks++;
        if (hi_dec !== 4'd4 || hi_unit !== 4'd2) $display("FAIL hiscore: %0d%0d, required 42", hi_dec, hi_unit);
        else passed++;
`endif
        go = 1'b0; y = 10'd100; step();
    endtask

    task automatic test_reset_mid_apply();
        y = 10'd100;
        eat = 1'b1; repeat (3) step(); eat = 1'b0;
        y = 10'd480; step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({score, pending, overflow, frame_update, busy} !== 13'd0)
            $display("FAIL reset_apply: score=%0d pending=%0d fu=%0d busy=%0d, required all 0", score, pending, frame_update, busy);
        else passed++;
        step();
        checks++;
        if (frame_update !== 1'b0 || busy !== 1'b0) $display("FAIL reset_apply_after: fu=%0d busy=%0d, required 0 0", frame_update, busy);
        else passed++;
    endtask

    task automatic test_random();
        int bad = 0;
        int first_bad = -1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: y = 10'd0;
                    1: y = 10'd100;
                    2: y = 10'd480;
                    default: y = 10'd520;
                endcase
            end
            eat = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 29) == 0) go = ~go;
            ng  = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
            if (score !== 7'(m_score) || score_dec !== 4'(m_score / 10) || score_unit !== 4'(m_score % 10) ||
                pending !== 3'(m_pend) || overflow !== m_ovf || frame_update !== m_fu || busy !== (m_mode != 0)
`ifdef SCORE_HIGH_SCORE_EN
                || hi_dec !== 4'(m_hi / 10) || hi_unit !== 4'(m_hi % 10)
`endif
                ) begin
                bad++;
                if (first_bad < 0) begin
                    first_bad = i;
                    $display("FAIL random_cycle %0d: score=%0d pend=%0d ovf=%0d fu=%0d busy=%0d, required %0d %0d %0d %0d %0d",
                             i, score, pending, overflow, frame_update, busy, m_score, m_pend, m_ovf, m_fu, m_mode != 0);
                end
            end
        end
        checks++;
        if (bad != 0) $display("FAIL random: %0d mismatching cycles, required 0", bad);
        else passed++;
        rst = 1'b0; eat = 1'b0; ng = 1'b0; go = 1'b0;
    endtask

    initial begin
        test_reset();
        test_apply_burst();
        test_carry();
        test_saturate();
        test_clear();
        test_overflow();
        test_game_over();
        test_reset_mid_apply();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
